alu_req_arbiter: RTL and testbench

- Shares the single registered ALU between two requesters: requester 0 is the execute stage, requester 1 is the address-generation/load-store path.
- Round-robin arbitration with a valid/ready request handshake.
- Sequences each accepted operation through the ALU's one-cycle registered latency, captures the result and flags, and returns them on a shared response bus with a per-requester valid/ready handshake.
- Rejects undefined ALU opcodes locally, without issuing them to the ALU.

---
 rtl/alu_req_arbiter_pkg.sv | 33 +++
 rtl/alu_req_arbiter_rr_arb2.sv | 34 +++
 rtl/alu_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter: ALU control codes,
// supported-code check and the sequencing state type.
package alu_pkg;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1010;
  localparam logic [3:0] ALU_SUBU = 4'b1011;
  localparam logic [3:0] ALU_ADDU = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT,
    RESP
  } state_t;

  function automatic logic alu_code_supported(input logic [3:0] code);
    case (code)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT,
      ALU_SLL, ALU_SRL, ALU_NOR, ALU_SUBU, ALU_ADDU: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-input arbiter: round-robin by default, or requester 0 always wins
// a tie when FIXED_PRIO is set. The pointer moves on each advance strobe.
module rr_arb2 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  // ptr_q = 0 favours requester 0 on a tie, 1 favours requester 1
  logic ptr_q;

  always_comb begin
    grant_o = '0;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ((FIXED_PRIO != 0) || !ptr_q) ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (advance_i) begin
      ptr_q <= grant_o[0];
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between the execute stage (req 0) and the
// load/store address path (req 1); returns result and flags per requester.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SHAMT_W    = 5,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_op_a,
  input  logic [2*DATA_W-1:0]   req_op_b,
  input  logic [7:0]            req_ctrl,
  input  logic [2*SHAMT_W-1:0]  req_shamt,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_overflow,
  output logic                  rsp_less,
  output logic                  rsp_err,
  output logic [DATA_W-1:0]     alu_operand_A,
  output logic [DATA_W-1:0]     alu_operand_B,
  output logic [3:0]            alu_control,
  output logic [SHAMT_W-1:0]    alu_shmant,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  input  logic                  alu_less,
  output logic                  busy,
  output logic                  grant_id
);

  state_t               state_q;
  logic                 grant_id_q;
  logic [DATA_W-1:0]    alu_a_q;
  logic [DATA_W-1:0]    alu_b_q;
  logic [3:0]           alu_ctrl_q;
  logic [SHAMT_W-1:0]   alu_sh_q;
  logic [1:0]           rsp_valid_q;
  logic [DATA_W-1:0]    rsp_result_q;
  logic                 rsp_zero_q;
  logic                 rsp_overflow_q;
  logic                 rsp_less_q;
  logic                 rsp_err_q;

  logic [1:0]           arb_req;
  logic [1:0]           grant;
  logic                 accept;
  logic                 gidx;
  logic [DATA_W-1:0]    a_sel;
  logic [DATA_W-1:0]    b_sel;
  logic [3:0]           ctrl_sel;
  logic [SHAMT_W-1:0]   sh_sel;

  // Arbitration is only exposed while idle, so req_ready is zero elsewhere
  assign arb_req = (state_q == IDLE) ? req_valid : 2'b00;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (arb_req),
    .advance_i(accept),
    .grant_o  (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign gidx      = grant[1];

  always_comb begin
    a_sel    = gidx ? req_op_a[2*DATA_W-1:DATA_W]   : req_op_a[DATA_W-1:0];
    b_sel    = gidx ? req_op_b[2*DATA_W-1:DATA_W]   : req_op_b[DATA_W-1:0];
    ctrl_sel = gidx ? req_ctrl[7:4]                 : req_ctrl[3:0];
    sh_sel   = gidx ? req_shamt[2*SHAMT_W-1:SHAMT_W] : req_shamt[SHAMT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_id_q     <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_ctrl_q     <= ALU_NOP;
      alu_sh_q       <= '0;
      rsp_valid_q    <= '0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_less_q     <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            grant_id_q <= gidx;
            if (alu_code_supported(ctrl_sel)) begin
              alu_a_q    <= a_sel;
              alu_b_q    <= b_sel;
              alu_ctrl_q <= ctrl_sel;
              alu_sh_q   <= sh_sel;
              state_q    <= EXEC;
            end else begin
              // Undefined codes never reach the ALU; answer directly with an error
              rsp_valid_q    <= gidx ? 2'b10 : 2'b01;
              rsp_result_q   <= '0;
              rsp_zero_q     <= 1'b0;
              rsp_overflow_q <= 1'b0;
              rsp_less_q     <= 1'b0;
              rsp_err_q      <= 1'b1;
              state_q        <= RESP;
            end
          end
        end
        EXEC: begin
          alu_a_q    <= '0;
          alu_b_q    <= '0;
          alu_ctrl_q <= ALU_NOP;
          alu_sh_q   <= '0;
          state_q    <= CAPT;
        end
        CAPT: begin
          rsp_result_q   <= alu_result;
          rsp_zero_q     <= alu_zero;
          rsp_overflow_q <= alu_overflow;
          rsp_less_q     <= alu_less;
          rsp_err_q      <= 1'b0;
          rsp_valid_q    <= grant_id_q ? 2'b10 : 2'b01;
          state_q        <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant_id_q]) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_operand_A = alu_a_q;
  assign alu_operand_B = alu_b_q;
  assign alu_control   = alu_ctrl_q;
  assign alu_shmant    = alu_sh_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_overflow  = rsp_overflow_q;
  assign rsp_less      = rsp_less_q;
  assign rsp_err       = rsp_err_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed plus randomized bench for alu_req_arbiter with a behavioural
// registered-ALU model and a transaction-level expectation model.
module tb_alu_req_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;

  logic            clk = 1'b0;
  logic            reset;
  always #5 clk = ~clk;

  logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*DW-1:0] req_op_a, req_op_b;
  logic [7:0]      req_ctrl;
  logic [2*SW-1:0] req_shamt;
  logic [DW-1:0]   rsp_result, alu_operand_A, alu_operand_B, alu_result;
  logic            rsp_zero, rsp_overflow, rsp_less, rsp_err;
  logic [3:0]      alu_control;
  logic [SW-1:0]   alu_shmant;
  logic            alu_zero, alu_overflow, alu_less, busy, grant_id;

  logic [1:0]      fp_req_valid, fp_req_ready, fp_rsp_valid;
  logic [1:0]      fp_rsp_ready = 2'b11;
  logic [DW-1:0]   fp_rsp_result, fp_alu_a, fp_alu_b;
  logic [DW-1:0]   fp_alu_result = '0;
  logic            fp_rsp_zero, fp_rsp_ov, fp_rsp_less, fp_rsp_err, fp_busy, fp_grant_id;
  logic            fp_alu_flag = 1'b0;
  logic [3:0]      fp_alu_ctrl;
  logic [SW-1:0]   fp_alu_sh;

  alu_req_arbiter #(.DATA_W(DW), .SHAMT_W(SW), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_ctrl(req_ctrl), .req_shamt(req_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_less(rsp_less), .rsp_err(rsp_err),
    .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B), .alu_control(alu_control),
    .alu_shmant(alu_shmant), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_less(alu_less), .busy(busy), .grant_id(grant_id)
  );

  alu_req_arbiter #(.DATA_W(DW), .SHAMT_W(SW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(fp_req_valid), .req_ready(fp_req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_ctrl(req_ctrl), .req_shamt(req_shamt),
    .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_result(fp_rsp_result),
    .rsp_zero(fp_rsp_zero), .rsp_overflow(fp_rsp_ov), .rsp_less(fp_rsp_less), .rsp_err(fp_rsp_err),
    .alu_operand_A(fp_alu_a), .alu_operand_B(fp_alu_b), .alu_control(fp_alu_ctrl),
    .alu_shmant(fp_alu_sh), .alu_result(fp_alu_result), .alu_zero(fp_alu_flag),
    .alu_overflow(fp_alu_flag), .alu_less(fp_alu_flag), .busy(fp_busy), .grant_id(fp_grant_id)
  );

  // ALU semantics: returns {overflow, less, zero, result}
  function automatic logic [34:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] s);
    logic [31:0] r;
    logic        ov;
    ov = 1'b0;
    case (c)
      4'd2:  begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd3:  begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~a;
      4'd8:  r = a << s;
      4'd9:  r = a >> s;
      4'd10: r = ~(a | b);
      4'd11: r = a - b;
      4'd12: r = a + b;
      default: r = '0;
    endcase
    return {ov, r[31], (r == 32'd0), r};
  endfunction

  // Registered ALU seen by the DUT
  always @(posedge clk)
    {alu_overflow, alu_less, alu_zero, alu_result} <= alu_fn(alu_control, alu_operand_A,
                                                              alu_operand_B, alu_shmant);

  int n_checks = 0;
  int n_errors = 0;
  int fav      = 0;   // requester favoured by the round-robin rule on a tie

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] vm, input logic [3:0] c0, input logic [3:0] c1,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic [4:0] s0, input logic [4:0] s1, input int stall);
    int          w;
    logic [3:0]  c;
    logic [31:0] a, b;
    logic [4:0]  s;
    logic [34:0] e;
    logic [1:0]  oh;
    logic        sup;
    w   = (vm == 2'b11) ? fav : (vm[1] ? 1 : 0);
    c   = (w == 1) ? c1 : c0;
    a   = (w == 1) ? a1 : a0;
    b   = (w == 1) ? b1 : b0;
    s   = (w == 1) ? s1 : s0;
    oh  = (w == 1) ? 2'b10 : 2'b01;
    sup = (c >= 4'd2) && (c <= 4'd12);
    e   = sup ? alu_fn(c, a, b, s) : 35'd0;
    req_valid = vm; req_ctrl = {c1, c0};
    req_op_a = {a1, a0}; req_op_b = {b1, b0}; req_shamt = {s1, s0};
    rsp_ready = (stall > 0) ? ~oh : 2'b11;
    #1;
    chk("idle_req_ready", req_ready, oh);
    chk("idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    fav = 1 - w;
    req_valid = vm & ~oh;
    chk("grant_id", grant_id, w[0]);
    chk("post_accept_busy", busy, 1'b1);
    if (sup) begin
      chk("exec_ctrl", alu_control, c);
      chk("exec_op_a", alu_operand_A, a);
      chk("exec_op_b", alu_operand_B, b);
      chk("exec_shamt", alu_shmant, s);
      chk("exec_req_ready", req_ready, 2'b00);
      chk("exec_rsp_valid", rsp_valid, 2'b00);
      @(posedge clk); #1;
      chk("capt_ctrl", alu_control, 4'b0000);
      chk("capt_op_a", alu_operand_A, 32'd0);
      chk("capt_req_ready", req_ready, 2'b00);
      chk("capt_rsp_valid", rsp_valid, 2'b00);
      @(posedge clk); #1;
    end else begin
      chk("err_alu_ctrl", alu_control, 4'b0000);
    end
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_result", rsp_result, e[31:0]);
    chk("rsp_zero", rsp_zero, e[32]);
    chk("rsp_less", rsp_less, e[33]);
    chk("rsp_overflow", rsp_overflow, e[34]);
    chk("rsp_err", rsp_err, !sup);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", rsp_valid, oh);
      chk("stall_result", rsp_result, e[31:0]);
      chk("stall_req_ready", req_ready, 2'b00);
      chk("stall_alu_ctrl", alu_control, 4'b0000);
    end
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    chk("done_rsp_valid", rsp_valid, 2'b00);
    chk("done_busy", busy, 1'b0);
    req_valid = 2'b00;
  endtask

  initial begin
    int grants;
    reset = 1'b1;
    req_valid = '0; req_op_a = '0; req_op_b = '0; req_ctrl = '0; req_shamt = '0;
    rsp_ready = '0; fp_req_valid = '0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_alu_ctrl", alu_control, 4'b0000);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_grant_id", grant_id, 1'b0);
    #10 reset = 1'b0;

    run_op(2'b01, 4'd2, 4'd0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd0, 5'd0, 0);
    run_op(2'b10, 4'd0, 4'd3, 32'd0, 32'd0, 32'd3, 32'd3, 5'd0, 5'd0, 0);
    for (int i = 0; i < 4; i++)
      run_op(2'b11, 4'd2, 4'd6, i, 32'd100, 32'hF0F0, i, 5'd0, 5'd0, 0);
    run_op(2'b01, 4'd8, 4'd0, 32'd1, 32'd0, 32'd0, 32'd0, 5'd4, 5'd0, 3);
    run_op(2'b10, 4'd2, 4'd15, 32'd9, 32'd9, 32'd9, 32'd9, 5'd0, 5'd0, 1);
    run_op(2'b01, 4'd2, 4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd0, 5'd0, 0);

    // Request withdrawn before any edge: no accept, pointer unchanged
    req_valid = 2'b10; #2; req_valid = 2'b00;
    @(posedge clk); #1;
    chk("withdraw_busy", busy, 1'b0);
    run_op(2'b11, 4'd4, 4'd5, 32'hFF00, 32'h0FF0, 32'hFF00, 32'h0FF0, 5'd0, 5'd0, 0);

    // Reset in EXEC discards the op
    req_valid = 2'b01; req_ctrl = {4'd0, 4'd2}; req_op_a = {32'd0, 32'd5}; req_op_b = {32'd0, 32'd5};
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b1; #1;
    fav = 0;
    chk("reset_exec_busy", busy, 1'b0);
    chk("reset_exec_rsp_valid", rsp_valid, 2'b00);
    chk("reset_exec_alu_ctrl", alu_control, 4'b0000);
    req_valid = 2'b11; #1;
    chk("reset_exec_req_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("after_reset_rsp_valid", rsp_valid, 2'b00);
    run_op(2'b01, 4'd2, 4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd0, 5'd0, 0);

    for (int i = 0; i < 30; i++)
      run_op(2'($urandom_range(1, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             $urandom, $urandom, $urandom, $urandom,
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom_range(0, 2));

    // Fixed priority instance: requester 0 wins every tie
    req_ctrl = {4'd2, 4'd2};
    fp_req_valid = 2'b11;
    grants = 0;
    for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
      #1;
      if (fp_req_ready != 2'b00) begin
        chk("fp_grant", fp_req_ready, 2'b01);
        grants++;
      end
      @(posedge clk); #1;
    end
    fp_req_valid = 2'b00;
    chk("fp_grant_count", grants, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
